stream_mult_pipe: RTL

STREAM_MULT_PIPE -- requirements
Module: stream_mult_pipe

---
 rtl/stream_mult_pkg.sv | 14 +
 rtl/stream_mult_pipe_if.sv | 28 ++
 rtl/stream_mult_stage.sv | 41 ++++
 rtl/stream_mult_pipe.sv | 108 ++++++++++
 4 files changed

// File: rtl/stream_mult_pkg.sv
// Shared constants and helpers for the stream multiplier pipeline.
package stream_mult_pkg;

  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 8;
  localparam int unsigned DEF_A_W    = 16;
  localparam int unsigned DEF_B_W    = 16;

  // Full product width: the product of an a_w-bit and a b_w-bit operand never exceeds a_w+b_w bits.
  function automatic int unsigned prod_w(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/stream_mult_pipe_if.sv
// Valid/ready stream bundle around stream_mult_pipe: operand beats in, product beats out.
// master = upstream producer / downstream consumer side, slave = the pipeline side.
interface stream_mult_pipe_if
  import stream_mult_pkg::*;
#(
  parameter int unsigned A_W = DEF_A_W,
  parameter int unsigned B_W = DEF_B_W
) ();

  logic                 i_valid;
  logic                 i_ready;
  logic [A_W-1:0]       i_payload_a;
  logic [B_W-1:0]       i_payload_b;
  logic                 o_valid;
  logic                 o_ready;
  logic [A_W+B_W-1:0]   o_payload;

  modport master (
    output i_valid, i_payload_a, i_payload_b, o_ready,
    input  i_ready, o_valid, o_payload
  );

  modport slave (
    input  i_valid, i_payload_a, i_payload_b, o_ready,
    output i_ready, o_valid, o_payload
  );

endinterface

// File: rtl/stream_mult_stage.sv
// One pipeline register stage: valid bit (async reset) plus data (no reset), loaded when en_i is high.
module stream_mult_stage #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // Load from the previous stage when enabled, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  // Valid bit clears immediately on reset so in-flight beats are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Data needs no reset; a bubble may carry anything.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_mult_pipe.sv
// Pipelined A x B multiplier with valid/ready flow control, STAGES registers deep.
// Optional build macro STREAM_MULT_XFER_CNT_EN adds a 32-bit output transfer counter (o_xfer_cnt).
module stream_mult_pipe
  import stream_mult_pkg::*;
#(
  parameter int unsigned A_W    = DEF_A_W,
  parameter int unsigned B_W    = DEF_B_W,
  parameter int unsigned STAGES = 3,
  parameter int unsigned SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [A_W-1:0]         i_payload_a,
  input  logic [B_W-1:0]         i_payload_b,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [A_W+B_W-1:0]     o_payload
`ifdef STREAM_MULT_XFER_CNT_EN
  ,
  output logic [31:0]            o_xfer_cnt
`endif
);

  localparam int unsigned P_W = prod_w(A_W, B_W);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $fatal(1, "stream_mult_pipe: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end

  logic                        stall;
  logic [P_W-1:0]              a_ext, b_ext, prod;
  logic                        s1_valid_q, s1_valid_d;
  logic [P_W-1:0]              s1_data_q,  s1_data_d;
  logic [STAGES-1:0]           vld;
  logic [STAGES-1:0][P_W-1:0]  dat;

  // Whole pipe freezes while the last stage holds an unaccepted product.
  assign stall   = o_valid && !o_ready;
  assign i_ready = !stall;

  // Operands are extended to the full product width (sign- or zero-fill), so the low
  // P_W bits of a single unsigned multiply are exact in both signed and unsigned modes.
  always_comb begin
    a_ext = {{B_W{(SIGNED != 0) && i_payload_a[A_W-1]}}, i_payload_a};
    b_ext = {{A_W{(SIGNED != 0) && i_payload_b[B_W-1]}}, i_payload_b};
    prod  = a_ext * b_ext;
  end

  // Stage 1 next state: capture the incoming beat and its product when not stalled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (!stall) begin
      s1_valid_d = i_valid;
      s1_data_d  = prod;
    end
  end

  // Stage 1 valid register with asynchronous discard.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_valid_q <= 1'b0;
    else          s1_valid_q <= s1_valid_d;
  end

  // Stage 1 product register.
  always_ff @(posedge clk) begin
    s1_data_q <= s1_data_d;
  end

  assign vld[0] = s1_valid_q;
  assign dat[0] = s1_data_q;

  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    stream_mult_stage #(.W(P_W)) u_stage (
      .clk     (clk),
      .rst_n   (reset_n),
      .en_i    (!stall),
      .valid_i (vld[k-1]),
      .data_i  (dat[k-1]),
      .valid_o (vld[k]),
      .data_o  (dat[k])
    );
  end

  assign o_valid   = vld[STAGES-1];
  assign o_payload = dat[STAGES-1];

`ifdef STREAM_MULT_XFER_CNT_EN
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  // Count completed output transfers, wrapping naturally at 2^32.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (o_valid && o_ready) xfer_cnt_d = xfer_cnt_q + 32'd1;
  end

  // Transfer counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) xfer_cnt_q <= '0;
    else          xfer_cnt_q <= xfer_cnt_d;
  end

  assign o_xfer_cnt = xfer_cnt_q;
`endif

endmodule
